// File: rtl/led_dance_gen_if.sv
// Switch/LED bundle between the board switch bank and the LED pattern generator.
// The generator takes the slave modport: it reads SW and drives led/step_tick.
interface led_dance_gen_if #(
    parameter int N_LEDS = 18
);
    logic [17:0]       SW;
    logic [N_LEDS-1:0] led;
    logic              step_tick;

    modport master (output SW, input led, input step_tick);
    modport slave  (input SW, output led, output step_tick);
endinterface

// File: rtl/led_dance_gen.sv
// LED animation generator: a free-running prescaler sets the step rate, and each
// step either loads a newly selected mode's start pattern or advances the current one.
module led_dance_gen #(
    parameter int N_LEDS     = 18,
    parameter int PRESCALE_W = 26
) (
    input  logic             Clock,
    input  logic             Reset,
    led_dance_gen_if.slave   bus
);
    localparam int POS_W = $clog2(N_LEDS + 1);
    localparam logic [POS_W-1:0] LAST = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] FULL = POS_W'(N_LEDS);

    typedef enum logic [2:0] {
        M_OFF     = 3'd0,
        M_CHASE_L = 3'd1,
        M_CHASE_R = 3'd2,
        M_BOUNCE  = 3'd3,
        M_BLINK   = 3'd4,
        M_FILL    = 3'd5,
        M_RSV6    = 3'd6,
        M_RSV7    = 3'd7
    } mode_e;

    function automatic logic [N_LEDS-1:0] alt_pattern();
        logic [N_LEDS-1:0] v;
        v = '0;
        for (int i = 0; i < N_LEDS; i++) v[i] = (i % 2 == 0);
        return v;
    endfunction

    localparam logic [N_LEDS-1:0] ALT = alt_pattern();

    function automatic logic [N_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
        return {{(N_LEDS-1){1'b0}}, 1'b1} << p;
    endfunction

    // A shift of N_LEDS or more clears everything, so pos = N_LEDS yields all lit.
    function automatic logic [N_LEDS-1:0] fill_mask(input logic [POS_W-1:0] p);
        return ~({N_LEDS{1'b1}} << p);
    endfunction

    logic [PRESCALE_W-1:0] r_cnt;
    logic [N_LEDS-1:0]     r_led;
    logic [POS_W-1:0]      r_pos;
    logic                  r_dir;
    mode_e                 r_mode;

    logic [PRESCALE_W-1:0] w_mask;
    logic [2:0]            w_speed;
    logic                  w_tick;
    logic                  w_step;
    mode_e                 w_sw_mode;
    logic [N_LEDS-1:0]     w_led_n;
    logic [POS_W-1:0]      w_pos_n;
    logic                  w_dir_n;
    mode_e                 w_mode_n;
    logic                  w_unused_sw;

    assign w_speed     = bus.SW[7:5];
    assign w_sw_mode   = mode_e'(bus.SW[2:0]);
    assign w_unused_sw = ^{bus.SW[17:8], bus.SW[3]};

    // Tick when the low (PRESCALE_W - speed) bits of the counter are all ones.
    assign w_mask = {PRESCALE_W{1'b1}} >> w_speed;
    assign w_tick = &(r_cnt | ~w_mask);
    assign w_step = w_tick & bus.SW[4];

    assign bus.step_tick = w_step;
    assign bus.led       = r_led;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cnt  <= '0;
            r_led  <= '0;
            r_pos  <= '0;
            r_dir  <= 1'b0;
            r_mode <= M_OFF;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_led  <= w_led_n;
            r_pos  <= w_pos_n;
            r_dir  <= w_dir_n;
            r_mode <= w_mode_n;
        end
    end

    always_comb begin
        w_led_n  = r_led;
        w_pos_n  = r_pos;
        w_dir_n  = r_dir;
        w_mode_n = r_mode;
        if (w_step) begin
            if (w_sw_mode != r_mode) begin
                // A mode switch only loads the start state; advancing begins next step.
                w_mode_n = w_sw_mode;
                w_dir_n  = 1'b0;
                case (w_sw_mode)
                    M_CHASE_L, M_BOUNCE: begin
                        w_pos_n = '0;
                        w_led_n = onehot('0);
                    end
                    M_CHASE_R: begin
                        w_pos_n = LAST;
                        w_led_n = onehot(LAST);
                    end
                    M_BLINK: begin
                        w_led_n = ALT;
                    end
                    M_FILL: begin
                        w_pos_n = POS_W'(1);
                        w_led_n = fill_mask(POS_W'(1));
                    end
                    default: begin
                        w_pos_n = '0;
                        w_led_n = '0;
                    end
                endcase
            end else begin
                case (r_mode)
                    M_CHASE_L: begin
                        w_pos_n = (r_pos == LAST) ? '0 : r_pos + 1'b1;
                        w_led_n = onehot(w_pos_n);
                    end
                    M_CHASE_R: begin
                        w_pos_n = (r_pos == '0) ? LAST : r_pos - 1'b1;
                        w_led_n = onehot(w_pos_n);
                    end
                    M_BOUNCE: begin
                        // Direction flips on arrival so each endpoint shows for one step.
                        if (!r_dir) begin
                            w_pos_n = r_pos + 1'b1;
                            if (w_pos_n == LAST) w_dir_n = 1'b1;
                        end else begin
                            w_pos_n = r_pos - 1'b1;
                            if (w_pos_n == '0) w_dir_n = 1'b0;
                        end
                        w_led_n = onehot(w_pos_n);
                    end
                    M_BLINK: begin
                        w_led_n = ~r_led;
                    end
                    M_FILL: begin
                        w_pos_n = (r_pos == FULL) ? '0 : r_pos + 1'b1;
                        w_led_n = fill_mask(w_pos_n);
                    end
                    default: begin
                        w_led_n = '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/led_dance_gen.md
# led_dance_gen

Parametrised LED pattern generator for the board LED bank, the next-generation replacement for the single-pattern chaser. It divides the system clock into a selectable step rate and drives one of several switch-selected animations (chase left/right, bounce, blink, bar fill) on an `N_LEDS`-wide registered LED bus. It sits directly between the board switches and the LED pins.

## Interface
- `N_LEDS`, default 18: number of LEDs driven; any value ≥ 2, not restricted to powers of two.
- `PRESCALE_W`, default 26: prescaler counter width; must be ≥ 8.
- `Clock`  in  1: system clock; all state updates on the rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `SW`  in  18: board switches. `SW[2:0]` selects the mode, `SW[4]` is run, `SW[7:5]` is speed; all other bits are ignored.
- `led`  out  N_LEDS: registered LED pattern.
- `step_tick`  out  1: combinational; high in every cycle where a pattern step is applied (tick AND run).

## Operation
- Prescaler `cnt` (PRESCALE_W bits):
  - Increments every cycle, wraps naturally and is never gated by run.
  - Speed `s` = `SW[7:5]`.
  - `tick` = 1 when the low `PRESCALE_W - s` bits of `cnt` are all ones, giving a step period of 2^(PRESCALE_W - s) cycles. `s = 0` is slowest.
- State registers:
  - `led`
  - `pos`, width clog2(N_LEDS+1)
  - `dir` (0 = up)
  - `mode_q` (3 bits)
- Step rule: state changes only on edges where `tick & SW[4]`. When `SW[4]` = 0, `led`, `pos`, `dir` and `mode_q` hold.
- Mode change: if `SW[2:0]` ≠ `mode_q` at a step, the step loads the new mode's init state, sets `mode_q` to `SW[2:0]` and does not advance. Later steps advance.
- Modes (init state / advance rule):
  - 0 OFF: `led` = 0; advance keeps `led` = 0.
  - 1 CHASE_L: init `pos` = 0, `led` = one-hot(0). Advance: `pos` = `pos` + 1; after N_LEDS-1 it wraps to 0. `led` = one-hot(`pos`).
  - 2 CHASE_R: init `pos` = N_LEDS-1. Advance: `pos` = `pos` - 1; after 0 it wraps to N_LEDS-1. `led` = one-hot(`pos`).
  - 3 BOUNCE: init `pos` = 0, `dir` = up.
    - Move one position per step in direction `dir`.
    - On reaching N_LEDS-1 set `dir` = down; on reaching 0 set `dir` = up.
    - Each endpoint is lit for exactly one step; the period is 2·N_LEDS-2 steps.
  - 4 BLINK: init `led` = alternating pattern with bit0 = 1. Advance: `led` = ~`led`.
  - 5 FILL: init `pos` = 1. `led` = low `pos` bits set.
    - Advance `pos` = `pos` + 1 up to N_LEDS (all lit).
    - The next step after all lit sets `pos` = 0 (all dark), then continues 1, 2, …
    - The period is N_LEDS+1 steps.
  - 6, 7 (reserved): behave as OFF.
- Every bit of `led` above N_LEDS-1 is non-existent; no one-hot or fill value ever exceeds the bus width.

## Timing
- Reset (asynchronous): `cnt` = 0, `led` = 0, `pos` = 0, `dir` = up, `mode_q` = 0. `led` reads 0 immediately on assertion and stays 0 while `Reset` is high, including when asserted mid-pattern.
- `step_tick` is 0 during reset.
- After release, the first tick occurs when `cnt` = 2^(PRESCALE_W-s)-1. With `s` = 7 (period 2) that is the 2nd edge after release.
- `led` changes only on the edge that ends a `step_tick` cycle. Latency from a switch change to a visible effect is at most one step period plus one cycle.
- Speed change takes effect at the next cycle's tick evaluation; there is no prescaler reset.
- Mode change while run = 0 is applied at the first step after run returns to 1.
- Run and mode toggling in the same cycle as a tick: the values sampled at that edge decide the step.

## Test plan
Benches use N_LEDS = 6, PRESCALE_W = 8, speed 7 (step every 2 cycles) unless stated otherwise.
- Reset then mode 1, run = 1 → `led` steps 000001, 000010, 000100, 001000, 010000, 100000, 000001. Assert `Reset` mid-sequence → `led` = 000000 in the same cycle, without waiting for a clock edge.
- Mode 2 → 100000, 010000, …, 000001, 100000. Switch to mode 3 mid-run → the next step shows 000001, then positions 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1 (period 10).
- Mode 4 → 010101, 101010, 010101. Mode 5 → 000001, 000011, …, 111111, 000000, 000001.
- With run = 0: `led` frozen, `step_tick` stays 0, `cnt` keeps counting. Change mode to 4 while frozen → no change; on run = 1 the first step shows 010101.
- Speed 0 → `step_tick` pulses exactly every 256 cycles. Speed 6 → every 4 cycles. Modes 6 and 7 → `led` = 000000 at the next step.
